// File: rtl/edge_event_counter_if.sv
// Control/compare inputs and pulse/count outputs of one digit of the counter chain.
interface edge_event_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             div_in;
  logic [WIDTH-1:0] match_val;
  logic [WIDTH-1:0] count;
  logic             edge_seen;
  logic             carry;
  logic             match;

  // Driver side: the upstream divider plus the control logic.
  modport master (
    output en, clr, div_in, match_val,
    input  count, edge_seen, carry, match
  );

  // Counter side.
  modport slave (
    input  en, clr, div_in, match_val,
    output count, edge_seen, carry, match
  );
endinterface

// File: rtl/edge_event_counter.sv
// Counts selected transitions of the divided signal modulo MOD, with carry and match pulses.
module edge_event_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10,
  parameter logic [1:0]  EDGE  = 2'b01
) (
  input  logic              CLK,
  input  logic              reset,
  edge_event_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

  // Reject illegal parameterisations at elaboration.
  if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("edge_event_counter: MOD out of range 2..2**WIDTH");
  end
  if (EDGE == 2'b00) begin : g_bad_edge
    $error("edge_event_counter: EDGE must select at least one transition");
  end

  logic             prev_q;
  logic             primed_q;
  logic [WIDTH-1:0] count_q;
  logic             edge_seen_q;
  logic             carry_q;
  logic             match_q;

  logic             rise_c;
  logic             fall_c;
  logic             qual_c;
  logic [WIDTH-1:0] count_d;
  logic             carry_d;
  logic             match_d;

  // Edge detection; primed masks the first sample after reset release.
  always_comb begin
    rise_c = bus.div_in & ~prev_q;
    fall_c = ~bus.div_in & prev_q;
    qual_c = primed_q & ((EDGE[0] & rise_c) | (EDGE[1] & fall_c));
  end

  // Next count and pulses: clear beats counting, counting beats hold.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    match_d = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (qual_c && bus.en) begin
      // >= also recovers from any out-of-range value by wrapping to zero.
      if (count_q >= TOP) begin
        count_d = '0;
        carry_d = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
      match_d = (count_d == bus.match_val);
    end
  end

  // Input history; updates every cycle independent of en/clr.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      prev_q   <= bus.div_in;
      primed_q <= 1'b1;
    end
  end

  // Count and output pulse registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      edge_seen_q <= 1'b0;
      carry_q     <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      edge_seen_q <= qual_c;
      carry_q     <= carry_d;
      match_q     <= match_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.edge_seen = edge_seen_q;
  assign bus.carry     = carry_q;
  assign bus.match     = match_q;

endmodule

// File: tb/tb_edge_event_counter.sv
// Randomised plus directed bench for edge_event_counter against a behavioural model.
module tb_edge_event_counter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned MOD   = 10;
  localparam int NDUT = 3;

  logic CLK;
  logic reset;
  logic en, clr, div_in;
  logic [WIDTH-1:0] match_val;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  edge_event_counter_if #(.WIDTH(WIDTH)) bus_r ();
  edge_event_counter_if #(.WIDTH(WIDTH)) bus_f ();
  edge_event_counter_if #(.WIDTH(WIDTH)) bus_b ();

  assign bus_r.en = en; assign bus_r.clr = clr; assign bus_r.div_in = div_in; assign bus_r.match_val = match_val;
  assign bus_f.en = en; assign bus_f.clr = clr; assign bus_f.div_in = div_in; assign bus_f.match_val = match_val;
  assign bus_b.en = en; assign bus_b.clr = clr; assign bus_b.div_in = div_in; assign bus_b.match_val = match_val;

  edge_event_counter #(.WIDTH(WIDTH), .MOD(MOD), .EDGE(2'b01)) u_r (.CLK(CLK), .reset(reset), .bus(bus_r));
  edge_event_counter #(.WIDTH(WIDTH), .MOD(MOD), .EDGE(2'b10)) u_f (.CLK(CLK), .reset(reset), .bus(bus_f));
  edge_event_counter #(.WIDTH(WIDTH), .MOD(MOD), .EDGE(2'b11)) u_b (.CLK(CLK), .reset(reset), .bus(bus_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: last input value, primed flag, and per-instance count/pulses.
  bit m_prev, m_primed;
  int m_cnt[NDUT];
  bit e_seen[NDUT], e_carry[NDUT], e_match[NDUT];
  bit rise_sel[NDUT] = '{1'b1, 1'b0, 1'b1};
  bit fall_sel[NDUT] = '{1'b0, 1'b1, 1'b1};
  int obs_seen[NDUT], obs_carry[NDUT], obs_match[NDUT];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL cyc=%0d %s actual=%0d required=%0d", cyc, name, act, exp);
  endtask

  task automatic clear_obs();
    for (int i = 0; i < NDUT; i++) begin
      obs_seen[i] = 0; obs_carry[i] = 0; obs_match[i] = 0;
    end
  endtask

  task automatic cmp_one(input int i, input int cnt, input bit es, input bit ca, input bit ma);
    check($sformatf("dut%0d.count", i), cnt, m_cnt[i]);
    check($sformatf("dut%0d.edge_seen", i), int'(es), int'(e_seen[i]));
    check($sformatf("dut%0d.carry", i), int'(ca), int'(e_carry[i]));
    check($sformatf("dut%0d.match", i), int'(ma), int'(e_match[i]));
    obs_seen[i]  += int'(es);
    obs_carry[i] += int'(ca);
    obs_match[i] += int'(ma);
  endtask

  // Advance model by one clock using current inputs, then compare every instance.
  task automatic step();
    bit q, rise, fall;
    if (!reset) begin
      m_prev = 1'b0; m_primed = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
        m_cnt[i] = 0; e_seen[i] = 0; e_carry[i] = 0; e_match[i] = 0;
      end
    end else begin
      rise = div_in && !m_prev;
      fall = !div_in && m_prev;
      for (int i = 0; i < NDUT; i++) begin
        q = m_primed && ((rise_sel[i] && rise) || (fall_sel[i] && fall));
        e_seen[i] = q;
        e_carry[i] = 1'b0;
        e_match[i] = 1'b0;
        if (clr) begin
          m_cnt[i] = 0;
        end else if (q && en) begin
          m_cnt[i] = (m_cnt[i] + 1) % MOD;
          e_carry[i] = (m_cnt[i] == 0);
          e_match[i] = (m_cnt[i] == int'(match_val));
        end
      end
      m_prev = div_in;
      m_primed = 1'b1;
    end
    @(posedge CLK);
    #1;
    cyc++;
    cmp_one(0, int'(bus_r.count), bus_r.edge_seen, bus_r.carry, bus_r.match);
    cmp_one(1, int'(bus_f.count), bus_f.edge_seen, bus_f.carry, bus_f.match);
    cmp_one(2, int'(bus_b.count), bus_b.edge_seen, bus_b.carry, bus_b.match);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; div_in = 1'b0; match_val = '0;
    #1;

    // Reset held: outputs stay zero regardless of activity.
    for (int k = 0; k < 20; k++) begin
      div_in = 1'($urandom); en = 1'($urandom);
      step();
    end
    check("reset_hold.count", int'(bus_r.count), 0);

    // Rising-edge counting with a period-12 square wave.
    div_in = 1'b0; en = 1'b1; match_val = 4'd5; reset = 1'b1;
    step();
    clear_obs();
    for (int p = 0; p < 10; p++) begin
      div_in = 1'b0; repeat (6) step();
      div_in = 1'b1; repeat (6) step();
    end
    check("sq.count_wrapped", int'(bus_r.count), 0);
    check("sq.carry_pulses", obs_carry[0], 1);
    check("sq.edge_pulses", obs_seen[0], 10);
    check("sq.match_pulses", obs_match[0], 1);

    // div_in high at reset release is not an edge.
    reset = 1'b0; div_in = 1'b1; step();
    reset = 1'b1; clear_obs();
    repeat (4) step();
    check("prime.no_edge", obs_seen[0], 0);
    div_in = 1'b0; step();
    div_in = 1'b1; step();
    check("prime.first_count", int'(bus_r.count), 1);

    // Drive rising count to 9, then clear coincident with a rising edge.
    for (int k = 0; k < 8; k++) begin
      div_in = 1'b0; step();
      div_in = 1'b1; step();
    end
    check("clr.pre_count", int'(bus_r.count), 9);
    match_val = 4'd0;
    div_in = 1'b0; step();
    div_in = 1'b1; clr = 1'b1; step();
    check("clr.count", int'(bus_r.count), 0);
    check("clr.carry", int'(bus_r.carry), 0);
    check("clr.match", int'(bus_r.match), 0);
    clr = 1'b0;

    // Edges while disabled are discarded but still reported.
    en = 1'b0; clear_obs();
    for (int k = 0; k < 3; k++) begin
      div_in = 1'b0; step();
      div_in = 1'b1; step();
    end
    check("en_off.count", int'(bus_r.count), 0);
    check("en_off.edge_pulses", obs_seen[0], 3);
    en = 1'b1;
    div_in = 1'b0; step();
    div_in = 1'b1; step();
    check("en_on.count", int'(bus_r.count), 1);

    // Both-edge counting with a toggling input and match at 3.
    reset = 1'b0; step();
    reset = 1'b1; div_in = 1'b0; match_val = 4'd3; step();
    clear_obs();
    for (int k = 0; k < 15; k++) begin
      div_in = ~div_in; step();
    end
    check("both.count", int'(bus_b.count), 5);
    check("both.match_pulses", obs_match[2], 2);
    check("both.carry_pulses", obs_carry[2], 1);
    match_val = 4'd12; clear_obs();
    for (int k = 0; k < 20; k++) begin
      div_in = ~div_in; step();
    end
    check("both.match_out_of_range", obs_match[2], 0);

    // Asynchronous reset takes effect between clock edges.
    #2 reset = 1'b0;
    #1 check("async_reset.count", int'(bus_b.count), 0);
    step();
    reset = 1'b1;

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) div_in = ~div_in;
      else if ($urandom_range(0, 2) == 0) div_in = 1'($urandom);
      en = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) match_val = WIDTH'($urandom_range(0, 15));
      reset = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
